// File: rtl/uart_pkg.sv
// Shared definitions for the UART message path.
// Contents: sequencer state encoding, link timing constants and
// control-character codes used by message tables and the sequencer.
package uart_pkg;

    // Sequencer state encoding
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_FETCH = 3'd2,
        S_REQ   = 3'd3,
        S_WAIT  = 3'd4,
        S_DONE  = 3'd5
    } seq_state_e;

    // Link timing shared with uart_tx
    localparam int unsigned CLK_HZ       = 100_000_000;
    localparam int unsigned BIT_RATE     = 9_600;
    localparam int unsigned PAYLOAD_BITS = 8;

    // Control characters
    localparam logic [7:0] CR  = 8'h0D;
    localparam logic [7:0] LF  = 8'h0A;
    localparam logic [7:0] FF  = 8'h0C;
    localparam logic [7:0] NUL = 8'h00;

endpackage

// File: rtl/uart_msg_sequencer_msg_byte_mux.sv
// Combinational byte selector: picks byte `ptr` of slot `idx` from the
// flat message table. Byte 0 is the most significant byte of the slot.
// Ports:
//   msg_table  flat table, slot i at [(i+1)*SLOT_W-1 : i*SLOT_W]
//   idx        slot index
//   ptr        byte pointer within the slot
//   byte_c     selected byte (combinational)
module msg_byte_mux #(
    parameter int unsigned MSG_BYTES = 16,
    parameter int unsigned NUM_MSGS  = 8,
    parameter int unsigned IDXW      = 3,
    parameter int unsigned PTRW      = 4
) (
    input  logic [NUM_MSGS*MSG_BYTES*8-1:0] msg_table,
    input  logic [IDXW-1:0]                 idx,
    input  logic [PTRW-1:0]                 ptr,
    output logic [7:0]                      byte_c
);

    localparam int unsigned SLOT_W = MSG_BYTES * 8;

    logic [SLOT_W-1:0] slot_c;

    // Slot select, then MSB-first byte select
    always_comb begin
        slot_c = msg_table[32'(idx) * SLOT_W +: SLOT_W];
        byte_c = slot_c[(MSG_BYTES - 1 - 32'(ptr)) * 8 +: 8];
    end

endmodule

// File: rtl/uart_msg_sequencer.sv
// Streams a range of fixed-width text messages byte by byte into uart_tx
// over its en/busy handshake, with wrap-around ranges, NUL suppression,
// abort, completion status and a saturating bytes-sent counter.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   msg_table             flat quasi-static message table
//   seq_start/first/last  start request and slot range (sampled together)
//   seq_abort             stop the running sequence
//   seq_busy/done/aborted sequence status
//   cur_idx, bytes_sent   slot in flight, bytes accepted by uart_tx
//   tx_data, tx_en        byte and enable toward uart_tx
//   tx_busy               uart_tx busy
module uart_msg_sequencer
    import uart_pkg::*;
#(
    parameter int unsigned MSG_BYTES = 16,
    parameter int unsigned NUM_MSGS  = 8,
    parameter int unsigned SKIP_NUL  = 1,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_MSGS*MSG_BYTES*8-1:0]   msg_table,
    input  logic                              seq_start,
    input  logic [$clog2(NUM_MSGS)-1:0]       seq_first,
    input  logic [$clog2(NUM_MSGS)-1:0]       seq_last,
    input  logic                              seq_abort,
    output logic                              seq_busy,
    output logic                              seq_done,
    output logic                              seq_aborted,
    output logic [$clog2(NUM_MSGS)-1:0]       cur_idx,
    output logic [CNT_W-1:0]                  bytes_sent,
    output logic [7:0]                        tx_data,
    output logic                              tx_en,
    input  logic                              tx_busy
);

    localparam int unsigned IDXW = $clog2(NUM_MSGS);
    localparam int unsigned PTRW = (MSG_BYTES > 1) ? $clog2(MSG_BYTES) : 1;

    seq_state_e       state_q, state_d;
    logic [IDXW-1:0]  first_q, first_d;
    logic [IDXW-1:0]  last_q, last_d;
    logic [IDXW-1:0]  cur_idx_q, cur_idx_d;
    logic [PTRW-1:0]  ptr_q, ptr_d;
    logic             abort_pend_q, abort_pend_d;
    logic [CNT_W-1:0] bytes_sent_q, bytes_sent_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_en_q, tx_en_d;
    logic             seq_busy_q, seq_busy_d;
    logic             seq_done_q, seq_done_d;
    logic             seq_aborted_q, seq_aborted_d;

    logic [7:0]       byte_c;
    logic             step_c;
    logic             finish_c;
    logic             aborting_c;

    msg_byte_mux #(
        .MSG_BYTES (MSG_BYTES),
        .NUM_MSGS  (NUM_MSGS),
        .IDXW      (IDXW),
        .PTRW      (PTRW)
    ) u_byte_mux (
        .msg_table (msg_table),
        .idx       (cur_idx_q),
        .ptr       (ptr_q),
        .byte_c    (byte_c)
    );

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            first_q       <= '0;
            last_q        <= '0;
            cur_idx_q     <= '0;
            ptr_q         <= '0;
            abort_pend_q  <= 1'b0;
            bytes_sent_q  <= '0;
            tx_data_q     <= '0;
            tx_en_q       <= 1'b0;
            seq_busy_q    <= 1'b0;
            seq_done_q    <= 1'b0;
            seq_aborted_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            first_q       <= first_d;
            last_q        <= last_d;
            cur_idx_q     <= cur_idx_d;
            ptr_q         <= ptr_d;
            abort_pend_q  <= abort_pend_d;
            bytes_sent_q  <= bytes_sent_d;
            tx_data_q     <= tx_data_d;
            tx_en_q       <= tx_en_d;
            seq_busy_q    <= seq_busy_d;
            seq_done_q    <= seq_done_d;
            seq_aborted_q <= seq_aborted_d;
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d       = state_q;
        first_d       = first_q;
        last_d        = last_q;
        cur_idx_d     = cur_idx_q;
        ptr_d         = ptr_q;
        abort_pend_d  = abort_pend_q;
        bytes_sent_d  = bytes_sent_q;
        tx_data_d     = tx_data_q;
        tx_en_d       = 1'b0;
        seq_busy_d    = seq_busy_q;
        seq_done_d    = 1'b0;
        seq_aborted_d = seq_aborted_q;
        step_c        = 1'b0;
        finish_c      = 1'b0;
        aborting_c    = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Start wins over a coincident abort
                if (seq_start) begin
                    first_d       = seq_first;
                    last_d        = seq_last;
                    bytes_sent_d  = '0;
                    seq_busy_d    = 1'b1;
                    seq_aborted_d = 1'b0;
                    abort_pend_d  = 1'b0;
                    state_d       = S_LOAD;
                end
            end
            S_LOAD: begin
                cur_idx_d = first_q;
                ptr_d     = '0;
                if (seq_abort) begin
                    finish_c   = 1'b1;
                    aborting_c = 1'b1;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                tx_data_d = byte_c;
                if (seq_abort) begin
                    finish_c   = 1'b1;
                    aborting_c = 1'b1;
                end else if ((SKIP_NUL != 0) && (byte_c == NUL)) begin
                    step_c = 1'b1;
                end else begin
                    tx_en_d = 1'b1;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                // Acceptance beats abort; an abort seen here is kept for WAIT
                if (tx_busy) begin
                    if (bytes_sent_q != {CNT_W{1'b1}}) begin
                        bytes_sent_d = bytes_sent_q + CNT_W'(1);
                    end
                    abort_pend_d = abort_pend_q | seq_abort;
                    state_d      = S_WAIT;
                end else if (seq_abort) begin
                    finish_c   = 1'b1;
                    aborting_c = 1'b1;
                end else begin
                    tx_en_d = 1'b1;
                end
            end
            S_WAIT: begin
                abort_pend_d = abort_pend_q | seq_abort;
                if (!tx_busy) begin
                    if (abort_pend_q || seq_abort) begin
                        finish_c   = 1'b1;
                        aborting_c = 1'b1;
                    end else begin
                        step_c = 1'b1;
                    end
                end
            end
            S_DONE: begin
                seq_busy_d = 1'b0;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Advance to the next byte, next slot (wrapping) or end of range
        if (step_c) begin
            if (ptr_q == PTRW'(MSG_BYTES - 1)) begin
                if (cur_idx_q == last_q) begin
                    finish_c = 1'b1;
                end else begin
                    cur_idx_d = cur_idx_q + IDXW'(1);
                    ptr_d     = '0;
                    state_d   = S_FETCH;
                end
            end else begin
                ptr_d   = ptr_q + PTRW'(1);
                state_d = S_FETCH;
            end
        end

        if (finish_c) begin
            state_d       = S_DONE;
            seq_done_d    = 1'b1;
            seq_aborted_d = aborting_c;
        end
    end

    assign seq_busy    = seq_busy_q;
    assign seq_done    = seq_done_q;
    assign seq_aborted = seq_aborted_q;
    assign cur_idx     = cur_idx_q;
    assign bytes_sent  = bytes_sent_q;
    assign tx_data     = tx_data_q;
    assign tx_en       = tx_en_q;

endmodule

// File: tb/tb_uart_msg_sequencer.sv
// Self-checking bench for uart_msg_sequencer with a uart_tx busy model
// and a byte/slot scoreboard.
module tb_uart_msg_sequencer;
    import uart_pkg::*;

    localparam int unsigned MSG_BYTES = 16;
    localparam int unsigned NUM_MSGS  = 8;
    localparam int unsigned CNT_W     = 16;
    localparam int unsigned SLOT_W    = MSG_BYTES * 8;
    localparam int          BUSY_LEN  = 10;

    logic                          clk;
    logic                          reset;
    logic [NUM_MSGS*SLOT_W-1:0]    msg_table;
    logic                          seq_start;
    logic [2:0]                    seq_first;
    logic [2:0]                    seq_last;
    logic                          seq_abort;
    logic                          seq_busy;
    logic                          seq_done;
    logic                          seq_aborted;
    logic [2:0]                    cur_idx;
    logic [CNT_W-1:0]              bytes_sent;
    logic [7:0]                    tx_data;
    logic                          tx_en;
    logic                          tx_busy;

    int n_run;
    int n_fail;

    logic [7:0] exp_byte_q[$];
    logic [2:0] exp_idx_q[$];

    int   busy_cnt;
    logic inhibit;
    int   done_cnt;
    int   en_rise_cnt;
    logic last_aborted;
    logic prev_en;

    uart_msg_sequencer #(
        .MSG_BYTES (MSG_BYTES),
        .NUM_MSGS  (NUM_MSGS),
        .SKIP_NUL  (1),
        .CNT_W     (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .msg_table   (msg_table),
        .seq_start   (seq_start),
        .seq_first   (seq_first),
        .seq_last    (seq_last),
        .seq_abort   (seq_abort),
        .seq_busy    (seq_busy),
        .seq_done    (seq_done),
        .seq_aborted (seq_aborted),
        .cur_idx     (cur_idx),
        .bytes_sent  (bytes_sent),
        .tx_data     (tx_data),
        .tx_en       (tx_en),
        .tx_busy     (tx_busy)
    );

    always #5 clk = ~clk;

    // uart_tx model: busy rises the cycle after en is seen, stays for BUSY_LEN cycles
    always @(posedge clk) begin
        if (reset)                      busy_cnt <= 0;
        else if (busy_cnt != 0)         busy_cnt <= busy_cnt - 1;
        else if (tx_en && !inhibit)     busy_cnt <= BUSY_LEN;
    end
    assign tx_busy = (busy_cnt != 0);

    // Scoreboard: each accepted byte is popped and compared
    always @(negedge clk) begin
        logic [7:0] eb;
        logic [2:0] ei;
        if (!reset) begin
            if (tx_en === 1'b1 && prev_en === 1'b0) en_rise_cnt++;
            if (tx_en === 1'b1 && tx_busy === 1'b1) begin
                n_run++;
                if (exp_byte_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_byte: got %02h idx %0d, required no byte", tx_data, cur_idx);
                end else begin
                    eb = exp_byte_q.pop_front();
                    ei = exp_idx_q.pop_front();
                    if (tx_data !== eb || cur_idx !== ei) begin
                        n_fail++;
                        $display("FAIL byte: got %02h idx %0d, required %02h idx %0d", tx_data, cur_idx, eb, ei);
                    end
                end
            end
            if (seq_done === 1'b1) begin
                done_cnt++;
                last_aborted = seq_aborted;
            end
        end
        prev_en = tx_en;
    end

    task automatic set_slot(input int i, input logic [SLOT_W-1:0] v);
        msg_table[i*SLOT_W +: SLOT_W] = v;
    endtask

    task automatic push_exp(input logic [7:0] b, input logic [2:0] idx);
        exp_byte_q.push_back(b);
        exp_idx_q.push_back(idx);
    endtask

    task automatic pulse_start(input logic [2:0] f, input logic [2:0] l);
        @(negedge clk);
        seq_start = 1'b1; seq_first = f; seq_last = l;
        @(negedge clk);
        seq_start = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clk);
            if (seq_busy === 1'b0) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_en(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clk);
            if (tx_en === 1'b1) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_run += 7;
        if (seq_busy !== 1'b0)    begin n_fail++; $display("FAIL reset_busy: got %b, required 0", seq_busy); end
        if (seq_done !== 1'b0)    begin n_fail++; $display("FAIL reset_done: got %b, required 0", seq_done); end
        if (seq_aborted !== 1'b0) begin n_fail++; $display("FAIL reset_aborted: got %b, required 0", seq_aborted); end
        if (cur_idx !== 3'd0)     begin n_fail++; $display("FAIL reset_idx: got %0d, required 0", cur_idx); end
        if (bytes_sent !== '0)    begin n_fail++; $display("FAIL reset_bytes: got %0d, required 0", bytes_sent); end
        if (tx_data !== 8'h00)    begin n_fail++; $display("FAIL reset_data: got %02h, required 00", tx_data); end
        if (tx_en !== 1'b0)       begin n_fail++; $display("FAIL reset_en: got %b, required 0", tx_en); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_slot();
        bit ok;
        int d0;
        d0 = done_cnt;
        set_slot(2, SLOT_W'({LF, CR, "CALC"}));
        push_exp(8'h0A, 3'd2); push_exp(8'h0D, 3'd2); push_exp(8'h43, 3'd2);
        push_exp(8'h41, 3'd2); push_exp(8'h4C, 3'd2); push_exp(8'h43, 3'd2);
        pulse_start(3'd2, 3'd2);
        wait_idle(2000, ok);
        n_run += 5;
        if (!ok) begin n_fail++; $display("FAIL single_timeout: busy still %b, required 0", seq_busy); end
        if (exp_byte_q.size() != 0) begin n_fail++; $display("FAIL single_missing: got %0d left, required 0", exp_byte_q.size()); end
        if (bytes_sent !== 16'd6) begin n_fail++; $display("FAIL single_bytes: got %0d, required 6", bytes_sent); end
        if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL single_done_cnt: got %0d, required 1", done_cnt - d0); end
        if (last_aborted !== 1'b0) begin n_fail++; $display("FAIL single_aborted: got %b, required 0", last_aborted); end
    endtask

    task automatic test_wrap();
        bit ok;
        int d0;
        d0 = done_cnt;
        set_slot(6, SLOT_W'("A")); set_slot(7, SLOT_W'("B"));
        set_slot(0, SLOT_W'("C")); set_slot(1, SLOT_W'("D"));
        push_exp(8'h41, 3'd6); push_exp(8'h42, 3'd7);
        push_exp(8'h43, 3'd0); push_exp(8'h44, 3'd1);
        pulse_start(3'd6, 3'd1);
        wait_idle(3000, ok);
        n_run += 4;
        if (!ok) begin n_fail++; $display("FAIL wrap_timeout: busy still %b, required 0", seq_busy); end
        if (exp_byte_q.size() != 0) begin n_fail++; $display("FAIL wrap_missing: got %0d left, required 0", exp_byte_q.size()); end
        if (bytes_sent !== 16'd4) begin n_fail++; $display("FAIL wrap_bytes: got %0d, required 4", bytes_sent); end
        if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL wrap_done_cnt: got %0d, required 1", done_cnt - d0); end
    endtask

    task automatic test_nul_slot();
        bit ok;
        set_slot(2, SLOT_W'("X")); set_slot(3, '0); set_slot(4, SLOT_W'("Y"));
        push_exp(8'h58, 3'd2); push_exp(8'h59, 3'd4);
        pulse_start(3'd2, 3'd4);
        wait_idle(2000, ok);
        n_run += 3;
        if (!ok) begin n_fail++; $display("FAIL nul_timeout: busy still %b, required 0", seq_busy); end
        if (exp_byte_q.size() != 0) begin n_fail++; $display("FAIL nul_missing: got %0d left, required 0", exp_byte_q.size()); end
        if (bytes_sent !== 16'd2) begin n_fail++; $display("FAIL nul_bytes: got %0d, required 2", bytes_sent); end
    endtask

    task automatic test_abort_wait();
        bit ok;
        int acc;
        int e0;
        e0 = en_rise_cnt;
        set_slot(5, SLOT_W'("ABCDEFGHIJKLMNOP"));
        push_exp(8'h41, 3'd5); push_exp(8'h42, 3'd5);
        @(negedge clk);
        seq_start = 1'b1; seq_first = 3'd5; seq_last = 3'd5;
        @(negedge clk);
        seq_start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_run++;
        if (tx_en !== 1'b1) begin n_fail++; $display("FAIL latency: tx_en got %b at start+3, required 1", tx_en); end
        acc = (tx_en === 1'b1 && tx_busy === 1'b1) ? 1 : 0;
        for (int c = 0; c < 500 && acc < 2; c++) begin
            @(negedge clk);
            if (tx_en === 1'b1 && tx_busy === 1'b1) acc++;
        end
        @(negedge clk);
        seq_abort = 1'b1;
        @(negedge clk);
        seq_abort = 1'b0;
        wait_idle(200, ok);
        n_run += 6;
        if (!ok) begin n_fail++; $display("FAIL abort_wait_timeout: busy still %b, required 0", seq_busy); end
        if (acc != 2) begin n_fail++; $display("FAIL abort_wait_reach: got %0d accepts, required 2", acc); end
        if (exp_byte_q.size() != 0) begin n_fail++; $display("FAIL abort_wait_missing: got %0d left, required 0", exp_byte_q.size()); end
        if (bytes_sent !== 16'd2) begin n_fail++; $display("FAIL abort_wait_bytes: got %0d, required 2", bytes_sent); end
        if (last_aborted !== 1'b1) begin n_fail++; $display("FAIL abort_wait_flag: got %b, required 1", last_aborted); end
        if (en_rise_cnt - e0 != 2) begin n_fail++; $display("FAIL abort_wait_en_cnt: got %0d, required 2", en_rise_cnt - e0); end
    endtask

    task automatic test_abort_req();
        bit ok;
        inhibit = 1'b1;
        pulse_start(3'd5, 3'd5);
        wait_en(20, ok);
        repeat (2) @(negedge clk);
        n_run += 2;
        if (!ok) begin n_fail++; $display("FAIL abort_req_en_timeout: tx_en got %b, required 1", tx_en); end
        if (tx_en !== 1'b1) begin n_fail++; $display("FAIL abort_req_hold: tx_en got %b, required 1", tx_en); end
        seq_abort = 1'b1;
        @(negedge clk);
        seq_abort = 1'b0;
        n_run++;
        if (tx_en !== 1'b0) begin n_fail++; $display("FAIL abort_req_drop: tx_en got %b, required 0", tx_en); end
        wait_idle(20, ok);
        n_run += 3;
        if (!ok) begin n_fail++; $display("FAIL abort_req_timeout: busy still %b, required 0", seq_busy); end
        if (bytes_sent !== 16'd0) begin n_fail++; $display("FAIL abort_req_bytes: got %0d, required 0", bytes_sent); end
        if (last_aborted !== 1'b1) begin n_fail++; $display("FAIL abort_req_flag: got %b, required 1", last_aborted); end
        inhibit = 1'b0;
    endtask

    task automatic test_restart_ignored();
        bit ok;
        int d0;
        int c;
        d0 = done_cnt;
        set_slot(7, SLOT_W'("PQ"));
        push_exp(8'h50, 3'd7); push_exp(8'h51, 3'd7);
        pulse_start(3'd7, 3'd7);
        c = 0;
        while (c < 100 && !(tx_en === 1'b1 && tx_busy === 1'b1)) begin
            @(negedge clk); c++;
        end
        @(negedge clk);
        seq_start = 1'b1; seq_first = 3'd0; seq_last = 3'd6;
        @(negedge clk);
        seq_start = 1'b0;
        wait_idle(500, ok);
        repeat (20) @(negedge clk);
        n_run += 5;
        if (!ok) begin n_fail++; $display("FAIL restart_timeout: busy still %b, required 0", seq_busy); end
        if (exp_byte_q.size() != 0) begin n_fail++; $display("FAIL restart_missing: got %0d left, required 0", exp_byte_q.size()); end
        if (bytes_sent !== 16'd2) begin n_fail++; $display("FAIL restart_bytes: got %0d, required 2", bytes_sent); end
        if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL restart_done_cnt: got %0d, required 1", done_cnt - d0); end
        if (seq_busy !== 1'b0) begin n_fail++; $display("FAIL restart_busy: got %b, required 0", seq_busy); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int d0;
        d0 = done_cnt;
        inhibit = 1'b1;
        pulse_start(3'd5, 3'd5);
        wait_en(20, ok);
        n_run++;
        if (!ok) begin n_fail++; $display("FAIL reset_mid_en_timeout: tx_en got %b, required 1", tx_en); end
        reset = 1'b1;
        @(negedge clk);
        n_run += 5;
        if (tx_en !== 1'b0)      begin n_fail++; $display("FAIL reset_mid_en: got %b, required 0", tx_en); end
        if (seq_busy !== 1'b0)   begin n_fail++; $display("FAIL reset_mid_busy: got %b, required 0", seq_busy); end
        if (bytes_sent !== '0)   begin n_fail++; $display("FAIL reset_mid_bytes: got %0d, required 0", bytes_sent); end
        if (seq_done !== 1'b0)   begin n_fail++; $display("FAIL reset_mid_done: got %b, required 0", seq_done); end
        if (done_cnt != d0)      begin n_fail++; $display("FAIL reset_mid_done_cnt: got %0d, required %0d", done_cnt, d0); end
        reset = 1'b0;
        inhibit = 1'b0;
        @(negedge clk);
        push_exp(8'h58, 3'd2); push_exp(8'h59, 3'd4);
        pulse_start(3'd2, 3'd4);
        wait_idle(2000, ok);
        n_run += 4;
        if (!ok) begin n_fail++; $display("FAIL after_reset_timeout: busy still %b, required 0", seq_busy); end
        if (exp_byte_q.size() != 0) begin n_fail++; $display("FAIL after_reset_missing: got %0d left, required 0", exp_byte_q.size()); end
        if (bytes_sent !== 16'd2) begin n_fail++; $display("FAIL after_reset_bytes: got %0d, required 2", bytes_sent); end
        if (last_aborted !== 1'b0) begin n_fail++; $display("FAIL after_reset_aborted: got %b, required 0", last_aborted); end
    endtask

    initial begin
        clk = 1'b0;
        reset = 1'b1;
        msg_table = '0;
        seq_start = 1'b0;
        seq_first = '0;
        seq_last = '0;
        seq_abort = 1'b0;
        inhibit = 1'b0;
        n_run = 0;
        n_fail = 0;
        done_cnt = 0;
        en_rise_cnt = 0;
        last_aborted = 1'b0;
        prev_en = 1'b0;

        test_reset();
        test_single_slot();
        test_wrap();
        test_nul_slot();
        test_abort_wait();
        test_abort_req();
        test_restart_ignored();
        test_reset_mid();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_msg_sequencer.md
Name: uart_msg_sequencer

Overview:
- Parametrised successor to the fixed-screen transmitter: holds a table of NUM_MSGS fixed-width text messages and streams a selected range of them, byte by byte, into the existing 8-bit uart_tx through its en/busy handshake.
- Sits between the application FSM (menu, calculator screens) and uart_tx.
- Adds over the previous generation: range selection with wrap-around, NUL-byte suppression, abort, completion status and a byte counter.

Parameters:
- MSG_BYTES, 16, characters per message slot; a message word is MSG_BYTES*8 bits.
- NUM_MSGS, 8, number of message slots; power of two, at least 2.
- SKIP_NUL, 1, when 1, bytes equal to 8'h00 are not transmitted.
- CNT_W, 16, width of the bytes-sent counter.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- msg_table  in  NUM_MSGS*MSG_BYTES*8  flat table; slot i occupies bits [(i+1)*MSG_BYTES*8-1 : i*MSG_BYTES*8]; quasi-static.
- seq_start  in  1  one-cycle request to send slots seq_first..seq_last.
- seq_first  in  IDXW=$clog2(NUM_MSGS)  first slot, sampled with seq_start.
- seq_last  in  IDXW  last slot, sampled with seq_start.
- seq_abort  in  1  stop the current sequence.
- seq_busy  out  1  high from acceptance of seq_start until seq_done.
- seq_done  out  1  one-cycle pulse at end of sequence.
- seq_aborted  out  1  valid with seq_done; 1 if ended by abort.
- cur_idx  out  IDXW  slot currently being sent.
- bytes_sent  out  CNT_W  bytes accepted by uart_tx in the current or last sequence.
- tx_data  out  8  byte to uart_tx.
- tx_en  out  1  uart_tx_en.
- tx_busy  in  1  uart_tx_busy.

Behaviour:
- Reset values: seq_busy=0, seq_done=0, seq_aborted=0, cur_idx=0, bytes_sent=0, tx_data=0, tx_en=0, state IDLE.
- Reset mid-operation drops tx_en in the next cycle, with no completion pulse.
- Byte order within a slot: MSB first. Byte k (k=0..MSG_BYTES-1) = slot bits [(MSG_BYTES-k)*8-1 -: 8]. A left-padded string such as {8'h0A,8'h0D,"HI"} therefore emits 0A 0D 'H' 'I' after skipped leading NULs.
- States:
  - IDLE: on seq_start, latch first/last, clear bytes_sent, set seq_busy, go to LOAD. seq_start while seq_busy is ignored.
  - LOAD: cur_idx <= first; byte pointer <= 0; go to FETCH.
  - FETCH: register byte into tx_data. If SKIP_NUL and the byte is 00, advance the pointer (one cycle per skipped byte); otherwise go to REQ.
  - REQ: tx_en=1, held until tx_busy is sampled high (accept). Then tx_en=0, bytes_sent++ (saturates at all-ones), go to WAIT.
  - WAIT: when tx_busy=0, advance. If bytes remain in the slot, go to FETCH. At the end of a slot: if cur_idx==last, go to DONE; else cur_idx <= cur_idx+1 (mod NUM_MSGS, so first>last wraps), pointer <= 0, go to FETCH.
  - DONE: seq_done=1 for one cycle; seq_busy <= 0; back to IDLE.
- Latency: seq_start sampled at cycle N gives first tx_en at N+3 if byte 0 is non-NUL.
- A slot with all bytes NUL emits nothing and costs MSG_BYTES cycles.
- first==last sends exactly one slot.
- Abort:
  - In FETCH or LOAD: go to DONE next cycle.
  - In REQ: drop tx_en, go to DONE; the unaccepted byte is not counted.
  - In WAIT: finish the current byte (wait busy low), then DONE.
  - seq_aborted=1 with seq_done. Abort in IDLE is ignored.
  - Abort and seq_start in the same IDLE cycle: start wins.
- tx_data is stable whenever tx_en=1.

Decomposition:
- Shared package uart_pkg:
  - state encoding localparams;
  - CLK_HZ=100_000_000, BIT_RATE=9_600, PAYLOAD_BITS=8;
  - character constants: CR=8'h0D, LF=8'h0A, FF=8'h0C, NUL=8'h00.
- One natural sub-module, msg_byte_mux: combinational selection of byte (slot idx, pointer) from msg_table. The sequencer FSM is the top.

Test Plan:
- NUM_MSGS=8, MSG_BYTES=16; slot 2 = {LF,CR,"CALC"}; start first=last=2 with a uart_tx model (busy 1 cycle after en, for 10 cycles) -> bytes 0A 0D 43 41 4C 43 in order; bytes_sent=6; one seq_done with seq_aborted=0.
- Wrap-around: slots 6,7,0,1 each hold "A".."D"; start first=6, last=1 -> emits 41 42 43 44; cur_idx sequence 6,7,0,1.
- All-NUL slot 3 between slots 2 ("X") and 4 ("Y"); range 2..4 -> emits 58 59 only; bytes_sent=2.
- Abort while tx_busy is high on the 2nd byte -> that byte completes, no 3rd tx_en, seq_done with seq_aborted=1, bytes_sent=2. Abort during REQ with busy held 0 -> tx_en drops next cycle, bytes_sent unchanged.
- seq_start pulsed again mid-sequence -> ignored; first/last unchanged; exactly one seq_done.
- Reset asserted mid-REQ -> next cycle tx_en=0, seq_busy=0, bytes_sent=0, no seq_done; a fresh start afterwards transmits normally.
